// File: rtl/sum_accumulator.sv
// Purpose : accumulates up to COUNT unsigned adder samples per frame and presents
//           the frame total, sample count and sticky overflow flag.
// Latency : the result is visible one cycle after the final input handshake; this
//           leaves a one-cycle gap between frames.
// Backpressure: in_ready drops while a result is held. out_* stay frozen until
//           out_ready completes the handshake.
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   in_valid/in_ready/in_sum/in_last
//                 sample stream from the adder (in_last ends the frame early)
//   out_valid/out_ready/out_acc/out_n/out_ovf
//                 frame result stream (total mod 2^ACC_W, sample count, carry seen)
module sum_accumulator #(
    parameter  int SIZE  = 8,
    parameter  int COUNT = 16,
    parameter  int ACC_W = 13,
    localparam int NW    = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE:0]     in_sum,
    input  logic              in_last,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [NW-1:0]     out_n,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [NW-1:0]    n;
    logic [NW-1:0]    n_nxt;
    logic             ovf;
    logic             ovf_nxt;

    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [NW-1:0]    n_inc;
    logic             frame_end;

    // The add is one bit wider than the accumulator so that its top bit is the
    // carry out of bit ACC_W-1. The carry feeds the sticky overflow flag.
    assign sum_wide  = {1'b0, acc} + {{(ACC_W - SIZE){1'b0}}, in_sum};
    assign n_inc     = n + NW'(1);
    assign frame_end = in_last | (n_inc == NW'(COUNT));

    // The handshake signals depend only on the state register. This keeps any
    // combinational path from in_valid or out_ready off the ready/valid outputs.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    assign out_acc   = acc;
    assign out_n     = n;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            n     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            n     <= n_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        n_nxt     = n;
        ovf_nxt   = ovf;

        case (state)
            ACCUM: begin
                if (accept) begin
                    acc_nxt = sum_wide[ACC_W-1:0];
                    ovf_nxt = ovf | sum_wide[ACC_W];
                    n_nxt   = n_inc;
                    if (frame_end) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // The frame is released only on the output handshake. Clearing
                // here means the next frame starts from zero in the following
                // cycle, which is the first cycle with in_ready high again.
                if (out_ready) begin
                    acc_nxt   = '0;
                    n_nxt     = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with SIZE=8, COUNT=4, ACC_W=10.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// The sampled values therefore reflect the preceding rising edge.
module tb_sum_accumulator;

    localparam int SIZE  = 8;
    localparam int COUNT = 4;
    localparam int ACC_W = 10;
    localparam int NW    = $clog2(COUNT + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE:0]     in_sum;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [NW-1:0]     out_n;
    logic              out_ovf;

    int n_checks;
    int n_fail;

    sum_accumulator #(
        .SIZE  (SIZE),
        .COUNT (COUNT),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_n     (out_n),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one sample for exactly one rising edge. The block is in ACCUM
    // whenever this is called, so the sample is accepted on that edge.
    task automatic send(input int val, input logic last);
        in_valid = 1'b1;
        in_sum   = val[SIZE:0];
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sum   = '0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int acc, input int n, input int ovf);
        chk_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk_eq({tag, " in_ready"},  32'(in_ready),  32'd0);
        chk_eq({tag, " out_acc"},   32'(out_acc),   acc);
        chk_eq({tag, " out_n"},     32'(out_n),     n);
        chk_eq({tag, " out_ovf"},   32'(out_ovf),   ovf);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_eq("rst out_acc",   32'(out_acc),   32'd0);
        chk_eq("rst out_n",     32'(out_n),     32'd0);
        chk_eq("rst out_ovf",   32'(out_ovf),   32'd0);
        chk_eq("rst out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst in_ready",  32'(in_ready),  32'd1);

        // Full frame: 1+2+3+4 = 10
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        chk_result("full", 10, 4, 0);
        drain();
        chk_eq("full post out_valid", 32'(out_valid), 32'd0);
        chk_eq("full post in_ready",  32'(in_ready),  32'd1);
        chk_eq("full post out_acc",   32'(out_acc),   32'd0);

        // Wrap: 4*511 = 2044, and 2044 mod 1024 = 1020, with a carry along the way
        for (int i = 0; i < 4; i++) send(511, 1'b0);
        chk_result("wrap", 1020, 4, 1);
        drain();
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        chk_result("wrap next", 4, 4, 0);
        drain();

        // in_last without in_valid has no effect
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_sum   = 9'd77;
        tick();
        in_last  = 1'b0;
        chk_eq("stray last out_valid", 32'(out_valid), 32'd0);
        chk_eq("stray last out_n",     32'(out_n),     32'd0);
        chk_eq("stray last out_acc",   32'(out_acc),   32'd0);
        // Early end: 7 + 9 = 16 with 2 samples
        send(7, 1'b0);
        send(9, 1'b1);
        chk_result("early", 16, 2, 0);
        drain();

        // Backpressure: hold the result while the upstream keeps offering data
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        in_valid = 1'b1;
        in_sum   = 9'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_result("bp hold", 10, 4, 0);
        end
        out_ready = 1'b1;
        tick();                       // handshake edge; the offered sample is not taken
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_eq("bp release in_ready",  32'(in_ready),  32'd1);
        chk_eq("bp release out_valid", 32'(out_valid), 32'd0);
        chk_eq("bp release out_n",     32'(out_n),     32'd0);
        chk_eq("bp release out_acc",   32'(out_acc),   32'd0);

        // Input gaps: 5, idle x3, 5, 5, 5 -> 20 with 4 samples
        send(5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_sum = 9'd33;           // data on an idle cycle must be ignored
            tick();
            chk_eq("gap out_n",   32'(out_n),   32'd1);
            chk_eq("gap out_acc", 32'(out_acc), 32'd5);
        end
        send(5, 1'b0); send(5, 1'b0); send(5, 1'b0);
        chk_result("gap", 20, 4, 0);
        drain();

        // Reset mid-frame discards the partial result
        send(100, 1'b0); send(100, 1'b0);
        chk_eq("mid partial out_n", 32'(out_n), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid rst out_acc",   32'(out_acc),   32'd0);
        chk_eq("mid rst out_n",     32'(out_n),     32'd0);
        chk_eq("mid rst out_ovf",   32'(out_ovf),   32'd0);
        chk_eq("mid rst out_valid", 32'(out_valid), 32'd0);
        chk_eq("mid rst in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 4; i++) send(2, 1'b0);
        chk_result("after rst", 8, 4, 0);

        // Reset while a result is pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("hold rst out_valid", 32'(out_valid), 32'd0);
        chk_eq("hold rst in_ready",  32'(in_ready),  32'd1);
        chk_eq("hold rst out_acc",   32'(out_acc),   32'd0);
        chk_eq("hold rst out_n",     32'(out_n),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Registered accumulator directly downstream of the parameterized ripple-carry adder stage. It consumes the adder's SIZE+1-bit sum output as a valid/ready stream and accumulates up to COUNT samples per frame into an ACC_W-bit register. It then presents the frame total, sample count and overflow flag on a valid/ready output port. It is the first clocked stage behind the combinational adder.

## Interface
- SIZE, 8: adder operand width; input sample width is SIZE+1.
- COUNT, 16: maximum samples per frame (≥1).
- ACC_W, 13: accumulator width (≥ SIZE+1).
- NW, $clog2(COUNT+1): width of sample-count output (derived, not overridden).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_sum holds a sample.
- in_ready  out  1  block can accept a sample this cycle.
- in_sum  in  SIZE+1  unsigned sample from adder.
- in_last  in  1  qualified by in_valid: this sample ends the frame early.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  frame total, modulo 2^ACC_W.
- out_n  out  NW  samples in frame (1..COUNT).
- out_ovf  out  1  sticky: a carry out of bit ACC_W-1 occurred during the frame.

## Operation
- Two states: ACCUM, HOLD. Reset state: ACCUM.
- Reset values: out_acc=0, out_n=0, out_ovf=0, out_valid=0; in_ready=1 after reset.
- ACCUM: in_ready=1, out_valid=0. An input is accepted when in_valid & in_ready.
  - On accept: {carry, acc} = acc + zero-extended in_sum, computed ACC_W+1 bits wide. acc takes the low ACC_W bits. ovf |= carry. n = n+1.
  - If the accepted sample has in_last=1, or the new n equals COUNT: move to HOLD.
- HOLD: in_ready=0, out_valid=1. out_acc, out_n and out_ovf hold stable.
  - On out_valid & out_ready: clear acc, n and ovf to 0 and move to ACCUM.
- in_last is ignored when in_valid=0. in_sum is unconstrained when in_valid=0.
- An empty frame cannot be produced. out_n is always ≥1 when out_valid=1.
- rst in any state, including mid-frame or in HOLD with a pending result, discards all data and returns to the reset values on the next edge. No partial result is emitted.
- out_valid is never deasserted in HOLD until the output handshake completes.

## Timing
- out_valid rises on the edge that accepts the final sample of a frame. The result is visible one cycle after the final input handshake.
- Throughput: one sample per cycle in ACCUM.
- One-cycle frame gap:
  - On the output-handshake edge the block enters ACCUM and asserts in_ready in the following cycle.
  - No input is accepted in the handshake cycle itself.
  - Best case is therefore COUNT+1 cycles per frame.
- in_ready depends only on state. There is no combinational path from in_valid or out_ready to in_ready.
- out_* are registered outputs with no combinational path from inputs.

## Test plan
Parameters for all scenarios: SIZE=8, COUNT=4, ACC_W=10.
- Full frame: accept samples 1, 2, 3, 4 on consecutive cycles -> out_valid=1 on the next cycle with out_acc=10, out_n=4, out_ovf=0, and in_ready=0.
- Overflow/wrap: accept 511, 511, 511, 511 -> out_acc=1020 (2044 mod 1024), out_n=4, out_ovf=1. The next frame 1, 1, 1, 1 -> out_acc=4, out_ovf=0 (sticky flag cleared).
- Early end: accept 7, then 9 with in_last=1 -> out_acc=16, out_n=2. in_last=1 driven while in_valid=0 before this -> no effect.
- Backpressure: complete a frame and hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, and out_* remain stable and unchanged. Raise out_ready -> the handshake occurs and in_ready=1 on the following cycle.
- Input gaps: accept 5, then 3 idle cycles, then 5, 5, 5 -> out_acc=20, out_n=4. Idle cycles must not advance n.
- Reset mid-frame: accept 100, 100, then assert rst for 1 cycle -> all outputs are 0 and in_ready=1. Then accept 2, 2, 2, 2 -> out_acc=8, out_n=4. Also assert rst while in HOLD -> out_valid=0 on the next cycle.
